// File: rtl/st_dma_buffer.sv
// rtl/st_dma_buffer.sv - ST DMA byte/word ping-pong buffer with mode, sector count and status registers
// Optional feature macro: ST_DMA_BYTECNT_EN (byte counter visible in status DOUT[15:7])
module st_dma_buffer #(
    parameter int BUF_WORDS    = 8,
    parameter int SECTOR_BYTES = 512
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        clk_en,
    input  logic        FCS_N,
    input  logic        RW,
    input  logic        A1,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic        RDY_I,
    output logic        RDY_O,
    input  logic        drq,
    output logic        dack,
    input  logic [7:0]  dev_din,
    output logic [7:0]  dev_dout
);
    localparam int WP_W  = $clog2(BUF_WORDS);
    localparam int BP_W  = WP_W + 1;
    localparam int BC_W  = $clog2(SECTOR_BYTES);
    localparam int WPS_W = $clog2(SECTOR_BYTES / 2);
    localparam int WL_W  = 8 + WPS_W;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(SECTOR_BYTES - 1);
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(BUF_WORDS - 1);
    localparam logic [BP_W-1:0] BP_LAST = BP_W'(2 * BUF_WORDS - 1);

    logic [15:0]     mem [2*BUF_WORDS];
    logic            dir, sc_sel, err, gap, rdy_d;
    logic [7:0]      seccnt;
    logic [BC_W-1:0] bytecnt;
    logic [1:0]      full;
    logic            dev_sel, mcu_sel;
    logic [BP_W-1:0] dev_ptr;
    logic [WP_W-1:0] mcu_ptr;
    logic [WL_W-1:0] words_left;

    logic            reg_wr, mode_wr, sc_wr, dir_flip, status_rd;
    logic            rdy_edge, sc_nz, dev_go, mcu_go, err_set;
    logic [WP_W:0]   dev_addr, mcu_addr;
    logic [7:0]      byte_rd;

    function automatic logic [WL_W-1:0] sec_words(input logic [7:0] s);
        return WL_W'(s) << WPS_W;
    endfunction

    assign reg_wr    = clk_en & ~FCS_N & ~RW;
    assign mode_wr   = reg_wr & A1;
    assign sc_wr     = reg_wr & ~A1 & sc_sel;
    assign dir_flip  = mode_wr & (DIN[8] != dir);
    assign status_rd = ~FCS_N & RW & A1;
    assign rdy_edge  = RDY_I & ~rdy_d;
    assign sc_nz     = (seccnt != 8'd0);
    assign err_set   = clk_en & drq & ~sc_nz & ~reg_wr;

    // Device side fills in dir=0 and drains in dir=1; MCU side is the opposite.
    assign dev_go = clk_en & drq & sc_nz & ~reg_wr & (dir ? full[dev_sel] : ~full[dev_sel]);
    assign RDY_O  = ~gap & (dir ? (~full[mcu_sel] & (words_left != '0)) : full[mcu_sel]);
    assign mcu_go = rdy_edge & RDY_O;

    assign dev_addr = {dev_sel, dev_ptr[BP_W-1:1]};
    assign mcu_addr = {mcu_sel, mcu_ptr};
    assign byte_rd  = dev_ptr[0] ? mem[dev_addr][7:0] : mem[dev_addr][15:8];

    always_ff @(posedge clk32) begin
        if (dev_go && !dir) begin
            if (!dev_ptr[0]) mem[dev_addr][15:8] <= dev_din;
            else             mem[dev_addr][7:0]  <= dev_din;
        end else if (mcu_go && dir) begin
            mem[mcu_addr] <= DIN;
        end
    end

    always_ff @(posedge clk32 or negedge resb) begin
        if (!resb) begin
            dir        <= 1'b0;
            sc_sel     <= 1'b0;
            err        <= 1'b0;
            gap        <= 1'b0;
            rdy_d      <= 1'b0;
            seccnt     <= 8'd0;
            bytecnt    <= '0;
            full       <= 2'b00;
            dev_sel    <= 1'b0;
            mcu_sel    <= 1'b0;
            dev_ptr    <= '0;
            mcu_ptr    <= '0;
            words_left <= '0;
            dack       <= 1'b0;
            dev_dout   <= 8'd0;
        end else begin
            rdy_d <= RDY_I;
            gap   <= 1'b0;
            if (clk_en) dack <= dev_go;
            if (dev_go && dir) dev_dout <= byte_rd;

            if (dir_flip) begin
                dir        <= DIN[8];
                sc_sel     <= DIN[4];
                err        <= 1'b0;
                gap        <= 1'b1;
                bytecnt    <= '0;
                full       <= 2'b00;
                dev_sel    <= 1'b0;
                mcu_sel    <= 1'b0;
                dev_ptr    <= '0;
                mcu_ptr    <= '0;
                words_left <= sec_words(seccnt);
            end else begin
                if (mode_wr) sc_sel <= DIN[4];
                if (err_set) err <= 1'b1;

                if (dev_go) begin
                    dev_ptr <= dev_ptr + BP_W'(1);
                    bytecnt <= bytecnt + BC_W'(1);
                    if (bytecnt == BC_LAST) seccnt <= seccnt - 8'd1;
                    if (dev_ptr == BP_LAST) begin
                        full[dev_sel] <= ~dir;
                        dev_sel       <= ~dev_sel;
                    end
                end

                if (mcu_go) begin
                    mcu_ptr <= mcu_ptr + WP_W'(1);
                    if (dir) words_left <= words_left - WL_W'(1);
                    // One idle cycle after each burst so the MCU sees RDY_O fall.
                    if (mcu_ptr == WP_LAST) begin
                        full[mcu_sel] <= dir;
                        mcu_sel       <= ~mcu_sel;
                        gap           <= 1'b1;
                    end
                end

                if (sc_wr) begin
                    seccnt     <= DIN[7:0];
                    bytecnt    <= '0;
                    words_left <= sec_words(DIN[7:0]);
                end
            end
        end
    end

    always_comb begin
        DOUT = 16'h0000;
        if (status_rd) begin
            DOUT[2:0] = {drq, sc_nz, ~err};
`ifdef ST_DMA_BYTECNT_EN
            DOUT[15:7] = 9'(bytecnt);
`else
`endif
        end else if (!dir && RDY_O) begin
            DOUT = mem[mcu_addr];
        end
    end

endmodule

// File: tb/tb_st_dma_buffer.sv
// tb/tb_st_dma_buffer.sv - scoreboard testbench for st_dma_buffer
`timescale 1ns/1ps
module tb_st_dma_buffer;
    logic        clk32 = 1'b0;
    logic        resb, clk_en, FCS_N, RW, A1, RDY_I, drq;
    logic [15:0] DIN, DOUT;
    logic        RDY_O, dack;
    logic [7:0]  dev_din, dev_dout;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_words[$];
    logic [7:0]  exp_bytes[$];
    bit          mon_words = 1'b0;
    bit          mon_bytes = 1'b0;
    bit          en_gate = 1'b0;
    int          en_cyc = 0;
    logic        prev_rdy = 1'b0;
    logic        prev_dack = 1'b0;
    logic [7:0]  hi_byte = 8'd0;
    bit          half = 1'b0;

    st_dma_buffer dut (
        .clk32(clk32), .resb(resb), .clk_en(clk_en), .FCS_N(FCS_N), .RW(RW), .A1(A1),
        .DIN(DIN), .DOUT(DOUT), .RDY_I(RDY_I), .RDY_O(RDY_O), .drq(drq), .dack(dack),
        .dev_din(dev_din), .dev_dout(dev_dout)
    );

    always #5 clk32 = ~clk32;

    initial begin
        clk_en = 1'b1;
        forever begin
            @(posedge clk32); #1;
            en_cyc++;
            clk_en = (en_gate && (en_cyc % 3 == 2)) ? 1'b0 : 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk32);
            if (resb) begin
                if (mon_words && RDY_I && !prev_rdy && RDY_O) begin
                    if (exp_words.size() == 0) check("word_unexpected", 32'(DOUT), 32'hFFFF_FFFF);
                    else check("mcu_word", 32'(DOUT), 32'(exp_words.pop_front()));
                end
                if (mon_bytes && dack && !prev_dack) begin
                    if (exp_bytes.size() == 0) check("byte_unexpected", 32'(dev_dout), 32'hFFFF_FFFF);
                    else check("dev_byte", 32'(dev_dout), 32'(exp_bytes.pop_front()));
                end
            end
            prev_rdy  = RDY_I;
            prev_dack = dack;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk32); #1; end
    endtask

    task automatic reg_write(input logic a1, input logic [15:0] d);
        FCS_N = 1'b0; RW = 1'b0; A1 = a1; DIN = d;
        tick(1);
        FCS_N = 1'b1; RW = 1'b1;
    endtask

    task automatic status_check(input string name, input logic [15:0] exp);
        FCS_N = 1'b0; RW = 1'b1; A1 = 1'b1;
        @(negedge clk32);
        check(name, 32'(DOUT), 32'(exp));
        tick(1);
        FCS_N = 1'b1;
    endtask

    task automatic dev_send(input logic [7:0] b, input int limit, output bit ok);
        dev_din = b; drq = 1'b1; ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(1);
            if (dack) ok = 1'b1;
        end
        drq = 1'b0;
        if (ok) begin
            if (!half) begin hi_byte = b; half = 1'b1; end
            else begin exp_words.push_back({hi_byte, b}); half = 1'b0; end
        end
        for (int i = 0; i < limit && dack; i++) tick(1);
    endtask

    task automatic dev_recv(input int limit, output bit ok);
        drq = 1'b1; ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(1);
            if (dack) ok = 1'b1;
        end
        drq = 1'b0;
        for (int i = 0; i < limit && dack; i++) tick(1);
    endtask

    task automatic wait_rdy(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (RDY_O) seen = 1'b1;
            else tick(1);
        end
    endtask

    task automatic mcu_read(input int n, input int limit, output int done);
        bit seen;
        done = 0;
        for (int w = 0; w < n; w++) begin
            wait_rdy(limit, seen);
            if (!seen) return;
            RDY_I = 1'b1; tick(1);
            RDY_I = 1'b0; tick(1);
            done++;
        end
    endtask

    task automatic mcu_write(input int n, input int limit, output int done);
        bit seen;
        logic [15:0] w;
        done = 0;
        for (int k = 0; k < n; k++) begin
            wait_rdy(limit, seen);
            if (!seen) return;
            w = {8'(8'hA0 + 2 * k), 8'(8'hA1 + 2 * k)};
            exp_bytes.push_back(w[15:8]);
            exp_bytes.push_back(w[7:0]);
            DIN = w; RDY_I = 1'b1; tick(1);
            RDY_I = 1'b0; tick(1);
            done++;
        end
    endtask

    initial begin
        bit ok, ok_d;
        int cnt, done, nbytes;
        resb = 1'b0; FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0; DIN = 16'h0000;
        RDY_I = 1'b0; drq = 1'b0; dev_din = 8'h00;

        // Reset state
        tick(3);
        check("rst_rdy_o", 32'(RDY_O), 32'd0);
        check("rst_dack", 32'(dack), 32'd0);
        check("rst_dout", 32'(DOUT), 32'd0);
        check("rst_dev_dout", 32'(dev_dout), 32'd0);
        resb = 1'b1;
        tick(1);
        status_check("rst_status", 16'h0001);

        // dir 1->0, seccnt=1, one buffer of bytes 00..0F then one burst
        reg_write(1'b1, 16'h0100);
        reg_write(1'b1, 16'h0010);
        reg_write(1'b0, 16'h0001);
        mon_words = 1'b1;
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            dev_send(8'(n), 200, ok);
            if (ok) cnt++;
        end
        check("fill16_dacks", 32'(cnt), 32'd16);
        tick(2);
        check("fill16_rdy_o", 32'(RDY_O), 32'd1);
        mcu_read(8, 200, done);
        check("burst1_words", 32'(done), 32'd8);
        check("burst1_rdy_low", 32'(RDY_O), 32'd0);
        check("burst1_drained", 32'(exp_words.size()), 32'd0);
        mon_words = 1'b0;

        // dir=1, seccnt=1: exactly 256 words requested, bytes A0,A1,... to device
        reg_write(1'b1, 16'h0110);
        reg_write(1'b0, 16'h0001);
        mon_bytes = 1'b1;
        en_gate = 1'b1;
        nbytes = 0;
        fork
            mcu_write(300, 400, done);
            begin
                for (int n = 0; n < 512; n++) begin
                    dev_recv(400, ok_d);
                    if (!ok_d) break;
                    nbytes++;
                end
            end
        join
        en_gate = 1'b0;
        tick(2);
        check("m2d_words", 32'(done), 32'd256);
        check("m2d_bytes", 32'(nbytes), 32'd512);
        check("m2d_rdy_low", 32'(RDY_O), 32'd0);
        check("m2d_drained", 32'(exp_bytes.size()), 32'd0);
        status_check("m2d_status", 16'h0001);
        mon_bytes = 1'b0;

        // dir=0, seccnt=2, 1024 bytes: seccnt reaches 0 at byte 1024, then error
        reg_write(1'b1, 16'h0010);
        reg_write(1'b0, 16'h0002);
        mon_words = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            nbytes = 0;
            fork
                mcu_read(256, 400, done);
                begin
                    for (int n = 0; n < 512; n++) begin
                        dev_send(8'((ph * 512 + n) * 3 + 5), 400, ok_d);
                        if (!ok_d) break;
                        nbytes++;
                    end
                end
            join
            check("sec_bytes", 32'(nbytes), 32'd512);
            check("sec_words", 32'(done), 32'd256);
            status_check("sec_status", ph == 0 ? 16'h0003 : 16'h0001);
        end
        dev_send(8'hEE, 20, ok);
        check("sec0_no_dack", 32'(ok), 32'd0);
        status_check("sec0_err", 16'h0000);

        // MCU stalled: device blocked after two full buffers, nothing lost afterwards
        reg_write(1'b1, 16'h0110);
        reg_write(1'b1, 16'h0010);
        reg_write(1'b0, 16'h0001);
        status_check("stall_status", 16'h0003);
        cnt = 0;
        for (int n = 0; n < 40; n++) begin
            dev_send(8'(8'h40 + cnt), 30, ok);
            if (ok) cnt++;
        end
        check("stall_dacks", 32'(cnt), 32'd32);
        check("stall_rdy_o", 32'(RDY_O), 32'd1);
        fork
            mcu_read(24, 300, done);
            begin
                for (int n = 32; n < 48; n++) begin
                    dev_send(8'(8'h40 + n), 300, ok_d);
                    if (!ok_d) break;
                end
            end
        join
        check("stall_words", 32'(done), 32'd24);
        check("stall_drained", 32'(exp_words.size()), 32'd0);

        // Reset asserted on the 4th word of a burst
        cnt = 0;
        for (int n = 0; n < 16; n++) begin
            dev_send(8'(8'h80 + n), 200, ok);
            if (ok) cnt++;
        end
        check("pre_rst_dacks", 32'(cnt), 32'd16);
        mcu_read(3, 200, done);
        check("pre_rst_words", 32'(done), 32'd3);
        RDY_I = 1'b1;
        #2 resb = 1'b0;
        #1;
        check("mid_rst_rdy_o", 32'(RDY_O), 32'd0);
        check("mid_rst_dout", 32'(DOUT), 32'd0);
        check("mid_rst_dack", 32'(dack), 32'd0);
        check("mid_rst_dev_dout", 32'(dev_dout), 32'd0);
        drq = 1'b1; FCS_N = 1'b0; RW = 1'b1; A1 = 1'b1;
        #1 check("mid_rst_status_drq", 32'(DOUT), 32'h0005);
        drq = 1'b0;
        #1 check("mid_rst_status", 32'(DOUT), 32'h0001);
        FCS_N = 1'b1; RDY_I = 1'b0;
        exp_words.delete();
        half = 1'b0;
        @(posedge clk32); #1;
        resb = 1'b1;
        tick(1);
        check("post_rst_rdy_o", 32'(RDY_O), 32'd0);
        status_check("post_rst_status", 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
